lut_index_gen: RTL and testbench

//  Versat datapath unit that generates two streams of table indices on out0/out1.

---
 rtl/lut_index_gen.sv | 200 ++++++++++++++++++++
 tb/tb_lut_index_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lut_index_gen.sv
// lut_index_gen: generates two streams of table indices for a downstream
// LookupTable. Each stream walks (start + k*incr) within a period and adds an
// extra shift at the end of every period, for a configured number of periods.
// Configuration is captured on run; done reports idle/finished.
// Optional feature: define LUT_INDEX_GEN_CLAMP_EN to add the limit port and
// clamp each emitted index to limit (the internal pointer still wraps).
module lut_index_gen #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int PERIOD_W = 10,
    parameter int ITER_W   = 10,
    parameter int DELAY_W  = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                running,
    output logic                done,
    input  logic [ADDR_W-1:0]   start_0,
    input  logic [ADDR_W-1:0]   start_1,
    input  logic [ADDR_W-1:0]   incr,
    input  logic [ADDR_W-1:0]   shift,
    input  logic [PERIOD_W-1:0] period,
    input  logic [ITER_W-1:0]   iterations,
    input  logic [DELAY_W-1:0]  delay,
`ifdef LUT_INDEX_GEN_CLAMP_EN
    input  logic [ADDR_W-1:0]   limit,
`endif
    output logic [DATA_W-1:0]   out0,
    output logic [DATA_W-1:0]   out1,
    output logic                out_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        GEN   = 2'd2
    } state_t;

    state_t              state_r, state_n;
    logic [ADDR_W-1:0]   ptr0_r, ptr0_n, ptr1_r, ptr1_n;
    logic [ADDR_W-1:0]   incr_r, incr_n, shift_r, shift_n;
    logic [PERIOD_W-1:0] period_r, period_n, inner_r, inner_n;
    logic [ITER_W-1:0]   iter_cfg_r, iter_cfg_n, iter_r, iter_n;
    logic [DELAY_W-1:0]  delay_r, delay_n, dcnt_r, dcnt_n;
    logic [DATA_W-1:0]   out0_r, out0_n, out1_r, out1_n;
    logic                valid_r, valid_n, done_r, done_n;
    logic [ADDR_W-1:0]   emit0_s, emit1_s;
    logic                start_s;

`ifdef LUT_INDEX_GEN_CLAMP_EN
    logic [ADDR_W-1:0]   limit_r, limit_n;

    assign emit0_s = (ptr0_r > limit_r) ? limit_r : ptr0_r;
    assign emit1_s = (ptr1_r > limit_r) ? limit_r : ptr1_r;
`else
    assign emit0_s = ptr0_r;
    assign emit1_s = ptr1_r;
`endif

    assign start_s   = run & running;
    assign out0      = out0_r;
    assign out1      = out1_r;
    assign out_valid = valid_r;
    assign done      = done_r;

    // Next-state and next-value logic: start has priority, then abort, then the FSM.
    always_comb begin
        state_n    = state_r;
        ptr0_n     = ptr0_r;
        ptr1_n     = ptr1_r;
        incr_n     = incr_r;
        shift_n    = shift_r;
        period_n   = period_r;
        iter_cfg_n = iter_cfg_r;
        delay_n    = delay_r;
        inner_n    = inner_r;
        iter_n     = iter_r;
        dcnt_n     = dcnt_r;
        out0_n     = out0_r;
        out1_n     = out1_r;
        valid_n    = 1'b0;
        done_n     = done_r;
`ifdef LUT_INDEX_GEN_CLAMP_EN
        limit_n    = limit_r;
`endif
        if (start_s) begin
            ptr0_n     = start_0;
            ptr1_n     = start_1;
            incr_n     = incr;
            shift_n    = shift;
            period_n   = period;
            iter_cfg_n = iterations;
            delay_n    = delay;
            inner_n    = PERIOD_W'(0);
            iter_n     = ITER_W'(0);
            dcnt_n     = DELAY_W'(0);
            done_n     = 1'b0;
`ifdef LUT_INDEX_GEN_CLAMP_EN
            limit_n    = limit;
`endif
            // A zero delay skips the wait so the first index lands one cycle after run.
            if (delay == DELAY_W'(0)) begin
                state_n = GEN;
            end else begin
                state_n = DELAY;
            end
        end else if ((state_r != IDLE) && !running) begin
            state_n = IDLE;
            done_n  = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    done_n = 1'b1;
                end
                DELAY: begin
                    if (dcnt_r == (delay_r - DELAY_W'(1))) begin
                        dcnt_n  = DELAY_W'(0);
                        state_n = GEN;
                    end else begin
                        dcnt_n = dcnt_r + DELAY_W'(1);
                    end
                end
                GEN: begin
                    if ((period_r == PERIOD_W'(0)) || (iter_cfg_r == ITER_W'(0))) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        out0_n  = DATA_W'(emit0_s);
                        out1_n  = DATA_W'(emit1_s);
                        valid_n = 1'b1;
                        if (inner_r == (period_r - PERIOD_W'(1))) begin
                            ptr0_n  = ptr0_r + incr_r + shift_r;
                            ptr1_n  = ptr1_r + incr_r + shift_r;
                            inner_n = PERIOD_W'(0);
                            if (iter_r == (iter_cfg_r - ITER_W'(1))) begin
                                iter_n  = ITER_W'(0);
                                state_n = IDLE;
                            end else begin
                                iter_n = iter_r + ITER_W'(1);
                            end
                        end else begin
                            ptr0_n  = ptr0_r + incr_r;
                            ptr1_n  = ptr1_r + incr_r;
                            inner_n = inner_r + PERIOD_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            endcase
        end
    end

    // State, configuration, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr0_r     <= ADDR_W'(0);
            ptr1_r     <= ADDR_W'(0);
            incr_r     <= ADDR_W'(0);
            shift_r    <= ADDR_W'(0);
            period_r   <= PERIOD_W'(0);
            iter_cfg_r <= ITER_W'(0);
            delay_r    <= DELAY_W'(0);
            inner_r    <= PERIOD_W'(0);
            iter_r     <= ITER_W'(0);
            dcnt_r     <= DELAY_W'(0);
            out0_r     <= DATA_W'(0);
            out1_r     <= DATA_W'(0);
            valid_r    <= 1'b0;
            done_r     <= 1'b1;
`ifdef LUT_INDEX_GEN_CLAMP_EN
            limit_r    <= ADDR_W'(0);
`endif
        end else begin
            state_r    <= state_n;
            ptr0_r     <= ptr0_n;
            ptr1_r     <= ptr1_n;
            incr_r     <= incr_n;
            shift_r    <= shift_n;
            period_r   <= period_n;
            iter_cfg_r <= iter_cfg_n;
            delay_r    <= delay_n;
            inner_r    <= inner_n;
            iter_r     <= iter_n;
            dcnt_r     <= dcnt_n;
            out0_r     <= out0_n;
            out1_r     <= out1_n;
            valid_r    <= valid_n;
            done_r     <= done_n;
`ifdef LUT_INDEX_GEN_CLAMP_EN
            limit_r    <= limit_n;
`endif
        end
    end

endmodule

// File: tb/tb_lut_index_gen.sv
// Testbench for lut_index_gen: table of configurations fed through a reference
// index model into a scoreboard queue, plus hand sequences for abort/restart
// and reset in the middle of generation.
module tb_lut_index_gen;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 8;
    localparam int PERIOD_W = 10;
    localparam int ITER_W   = 10;
    localparam int DELAY_W  = 7;

    logic                clk = 1'b0;
    logic                rst;
    logic                run;
    logic                running;
    logic                done;
    logic [ADDR_W-1:0]   start_0, start_1, incr, shift;
    logic [PERIOD_W-1:0] period;
    logic [ITER_W-1:0]   iterations;
    logic [DELAY_W-1:0]  delay;
    logic [ADDR_W-1:0]   limit = 8'd5;
    logic [DATA_W-1:0]   out0, out1;
    logic                out_valid;

    lut_index_gen dut (
        .clk(clk), .rst(rst), .run(run), .running(running), .done(done),
        .start_0(start_0), .start_1(start_1), .incr(incr), .shift(shift),
        .period(period), .iterations(iterations), .delay(delay),
`ifdef LUT_INDEX_GEN_CLAMP_EN
        .limit(limit),
`endif
        .out0(out0), .out1(out1), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s0, s1, inc, shf;
        int         per, its, dly;
        int         exp_n;
        logic [7:0] exp_first0;
    } vec_t;

    typedef struct {
        logic [7:0] i0, i1;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] clampf(input logic [7:0] p);
`ifdef LUT_INDEX_GEN_CLAMP_EN
        return (p > limit) ? limit : p;
`else
        return p;
`endif
    endfunction

    // Reference model: nested loop over periods, pushes every expected index pair.
    task automatic model_push(input vec_t v);
        logic [7:0] p0, p1;
        exp_t e;
        p0 = v.s0;
        p1 = v.s1;
        for (int it = 0; it < v.its; it++) begin
            for (int k = 0; k < v.per; k++) begin
                e.i0 = clampf(p0);
                e.i1 = clampf(p1);
                sb.push_back(e);
                p0 = p0 + v.inc;
                p1 = p1 + v.inc;
            end
            p0 = p0 + v.shf;
            p1 = p1 + v.shf;
        end
    endtask

    task automatic drive_run(input vec_t v);
        @(negedge clk);
        start_0 = v.s0; start_1 = v.s1; incr = v.inc; shift = v.shf;
        period = PERIOD_W'(v.per); iterations = ITER_W'(v.its); delay = DELAY_W'(v.dly);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        // Scramble config after run: it must have been latched.
        start_0 = 8'($urandom); start_1 = 8'($urandom);
        incr = 8'($urandom); shift = 8'($urandom);
        period = PERIOD_W'($urandom); iterations = ITER_W'($urandom);
        delay = DELAY_W'($urandom);
    endtask

    // Issue one run and follow it cycle by cycle; abort_at>0 drops running at that valid.
    task automatic run_vec(input vec_t v, input int abort_at);
        int   n, got;
        exp_t e;
        logic [7:0] last0;
        model_push(v);
        n = sb.size();
        got = 0;
        last0 = 8'd0;
        drive_run(v);
        check("done_low_after_run", {31'd0, done}, 32'd0);
        for (int c = 1; c <= v.dly + n + 2; c++) begin
            @(negedge clk);
            if (n > 0 && c == v.dly + n + 1 && abort_at == 0)
                check("done_after_last", {31'd0, done}, 32'd1);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("extra_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out0", out0, {24'd0, e.i0});
                    check("out1", out1, {24'd0, e.i1});
                    check("valid_cycle", c, v.dly + 1 + got);
                    if (got == 0) check("first0", out0, {24'd0, clampf(v.exp_first0)});
                    last0 = e.i0;
                    got++;
                    if (abort_at > 0 && got == abort_at) begin
                        running = 1'b0;
                        break;
                    end
                end
            end
        end
        if (abort_at > 0) begin
            @(negedge clk);
            check("abort_valid", {31'd0, out_valid}, 32'd0);
            check("abort_done", {31'd0, done}, 32'd1);
            check("abort_hold0", out0, {24'd0, last0});
            running = 1'b1;
            sb.delete();
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("abort_quiet", {31'd0, out_valid}, 32'd0);
            end
        end else begin
            check("count", got, v.exp_n);
            check("pending", sb.size(), 0);
            check("done_end", {31'd0, done}, 32'd1);
            check("valid_end", {31'd0, out_valid}, 32'd0);
        end
    endtask

    vec_t tbl[7];
    vec_t hv;

    initial begin
        tbl[0] = '{s0:8'h00, s1:8'h10, inc:8'h01, shf:8'h00, per:4,  its:2, dly:0, exp_n:8,  exp_first0:8'h00};
        tbl[1] = '{s0:8'h02, s1:8'h80, inc:8'h02, shf:8'hF8, per:4,  its:3, dly:3, exp_n:12, exp_first0:8'h02};
        tbl[2] = '{s0:8'hFE, s1:8'hFF, inc:8'h01, shf:8'h00, per:4,  its:1, dly:1, exp_n:4,  exp_first0:8'hFE};
        tbl[3] = '{s0:8'h03, s1:8'h00, inc:8'h01, shf:8'h00, per:5,  its:1, dly:0, exp_n:5,  exp_first0:8'h03};
        tbl[4] = '{s0:8'h10, s1:8'h20, inc:8'hFF, shf:8'h03, per:3,  its:3, dly:2, exp_n:9,  exp_first0:8'h10};
        tbl[5] = '{s0:8'h07, s1:8'h08, inc:8'h01, shf:8'h00, per:0,  its:2, dly:4, exp_n:0,  exp_first0:8'h00};
        tbl[6] = '{s0:8'h07, s1:8'h08, inc:8'h01, shf:8'h00, per:3,  its:0, dly:0, exp_n:0,  exp_first0:8'h00};

        rst = 1'b1; run = 1'b0; running = 1'b1;
        start_0 = 8'd0; start_1 = 8'd0; incr = 8'd0; shift = 8'd0;
        period = 10'd0; iterations = 10'd0; delay = 7'd0;
        repeat (2) @(negedge clk);
        check("rst_done", {31'd0, done}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out0", out0, 32'd0);
        check("rst_out1", out1, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(tbl[i], 0);

        // Abort at the third valid, then restart at a new start index.
        hv = '{s0:8'h00, s1:8'h40, inc:8'h01, shf:8'h00, per:10, its:1, dly:0, exp_n:10, exp_first0:8'h00};
        run_vec(hv, 3);
        hv = '{s0:8'h05, s1:8'h41, inc:8'h01, shf:8'h00, per:2,  its:1, dly:0, exp_n:2,  exp_first0:8'h05};
        run_vec(hv, 0);

        // Reset in the middle of generation returns straight to reset values.
        hv = '{s0:8'h01, s1:8'h02, inc:8'h01, shf:8'h00, per:8,  its:1, dly:0, exp_n:8,  exp_first0:8'h01};
        drive_run(hv);
        repeat (2) @(negedge clk);
        check("mid_valid_before_rst", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd1);
        check("mid_rst_out0", out0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_quiet", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
